iob_ptfloat_div_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one iterative pt-float divider among `N_REQ` requesters. It accepts a request, latches the operands, and pulses the divider start. It then waits for the divider's done pulse (with a timeout) and returns the result to the winning requester over a valid/ready response port. Zero divisors are short-circuited without occupying the divider. The block sits between the FPU issue logic and the `iob_ptfloat_div` datapath.

---
 rtl/iob_ptfloat_div_ctrl_pkg.sv | 34 +++
 rtl/iob_rr_arbiter.sv | 39 +++
 rtl/iob_ptfloat_div_ctrl.sv | 162 ++++++++++++++++
 tb/tb_iob_ptfloat_div_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_ptfloat_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// iob_ptfloat_div_ctrl_pkg : shared widths, state encodings and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iob_ptfloat_div_ctrl_pkg;

    localparam int EXP_MAX_W = 8;
    localparam int MAN_MAX_W = 24;
    localparam int RES_MAX_W = 24;

    localparam logic [1:0] DIVC_IDLE  = 2'd0;
    localparam logic [1:0] DIVC_START = 2'd1;
    localparam logic [1:0] DIVC_BUSY  = 2'd2;
    localparam logic [1:0] DIVC_RESP  = 2'd3;

    localparam int DIVC_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = DIVC_IDLE,
        ST_START = DIVC_START,
        ST_BUSY  = DIVC_BUSY,
        ST_RESP  = DIVC_RESP
    } divc_state_e;

    // Successor of a requester index, wrapping modulo n.
    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_rr_arbiter.sv
// ---------------------------------------------------------------------------
// iob_rr_arbiter : combinational round-robin pick, first valid at/after ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iob_rr_arbiter
    import iob_ptfloat_div_ctrl_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_valid
);

    logic [ID_W-1:0] slot;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        slot      = '0;
        for (int k = 0; k < N; k++) begin
            slot = ID_W'((int'(ptr) + k) % N);
            if (!any_valid && req[slot]) begin
                grant[slot] = 1'b1;
                grant_idx   = slot;
                any_valid   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_ptfloat_div_ctrl.sv
// ---------------------------------------------------------------------------
// iob_ptfloat_div_ctrl : shares one iterative pt-float divider among N_REQ
// requesters with round-robin arbitration, zero-divisor bypass and timeout.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iob_ptfloat_div_ctrl
    import iob_ptfloat_div_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DIVC_TIMEOUT,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         cke_i,

    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*EXP_MAX_W-1:0]   req_exp_a_i,
    input  logic [N_REQ*EXP_MAX_W-1:0]   req_exp_b_i,
    input  logic [N_REQ*MAN_MAX_W-1:0]   req_man_a_i,
    input  logic [N_REQ*MAN_MAX_W-1:0]   req_man_b_i,

    output logic [N_REQ-1:0]             rsp_valid_o,
    input  logic [N_REQ-1:0]             rsp_ready_i,
    output logic [EXP_MAX_W+1:0]         rsp_exp_o,
    output logic [RES_MAX_W-1:0]         rsp_man_o,
    output logic                         rsp_dbz_o,
    output logic                         rsp_tmo_o,

    output logic                         div_start_o,
    input  logic                         div_done_i,
    output logic [EXP_MAX_W-1:0]         div_exp_a_o,
    output logic [EXP_MAX_W-1:0]         div_exp_b_o,
    output logic [MAN_MAX_W-1:0]         div_man_a_o,
    output logic [MAN_MAX_W-1:0]         div_man_b_o,
    input  logic [EXP_MAX_W+1:0]         div_exp_i,
    input  logic [RES_MAX_W-1:0]         div_man_i,

    output logic                         busy_o,
    output logic [ID_W-1:0]              grant_id_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    divc_state_e      state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] tmo_cnt;

    logic [N_REQ-1:0] arb_grant;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;

    logic [EXP_MAX_W-1:0] exp_a_arr [N_REQ];
    logic [EXP_MAX_W-1:0] exp_b_arr [N_REQ];
    logic [MAN_MAX_W-1:0] man_a_arr [N_REQ];
    logic [MAN_MAX_W-1:0] man_b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign exp_a_arr[g] = req_exp_a_i[g*EXP_MAX_W +: EXP_MAX_W];
        assign exp_b_arr[g] = req_exp_b_i[g*EXP_MAX_W +: EXP_MAX_W];
        assign man_a_arr[g] = req_man_a_i[g*MAN_MAX_W +: MAN_MAX_W];
        assign man_b_arr[g] = req_man_b_i[g*MAN_MAX_W +: MAN_MAX_W];
    end

    iob_rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    // Gated by cke_i so a frozen controller never signals an accept it will not take.
    assign req_ready_o = (state == ST_IDLE && cke_i) ? arb_grant : '0;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            grant_id_o  <= '0;
            busy_o      <= 1'b0;
            div_start_o <= 1'b0;
            div_exp_a_o <= '0;
            div_exp_b_o <= '0;
            div_man_a_o <= '0;
            div_man_b_o <= '0;
            rsp_valid_o <= '0;
            rsp_exp_o   <= '0;
            rsp_man_o   <= '0;
            rsp_dbz_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
        end else if (cke_i) begin
            div_start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_id_o  <= arb_idx;
                        busy_o      <= 1'b1;
                        div_exp_a_o <= exp_a_arr[arb_idx];
                        div_exp_b_o <= exp_b_arr[arb_idx];
                        div_man_a_o <= man_a_arr[arb_idx];
                        div_man_b_o <= man_b_arr[arb_idx];
                        if (man_b_arr[arb_idx] == '0) begin
                            rsp_dbz_o   <= 1'b1;
                            rsp_tmo_o   <= 1'b0;
                            rsp_exp_o   <= '0;
                            rsp_man_o   <= '0;
                            rsp_valid_o <= arb_grant;
                            state       <= ST_RESP;
                        end else begin
                            div_start_o <= 1'b1;
                            state       <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    tmo_cnt <= '0;
                    state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    // done is tested first so it wins over a coincident timeout
                    if (div_done_i) begin
                        rsp_exp_o   <= div_exp_i;
                        rsp_man_o   <= div_man_i;
                        rsp_dbz_o   <= 1'b0;
                        rsp_tmo_o   <= 1'b0;
                        rsp_valid_o <= N_REQ'(1) << grant_id_o;
                        state       <= ST_RESP;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_exp_o   <= '0;
                        rsp_man_o   <= '0;
                        rsp_dbz_o   <= 1'b0;
                        rsp_tmo_o   <= 1'b1;
                        rsp_valid_o <= N_REQ'(1) << grant_id_o;
                        state       <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[grant_id_o]) begin
                        rsp_valid_o <= '0;
                        rr_ptr      <= ID_W'(rr_next(int'(grant_id_o), N_REQ));
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iob_ptfloat_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_ptfloat_div_ctrl : directed self-checking bench for the divider controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iob_ptfloat_div_ctrl;

    localparam int N  = 4;
    localparam int EW = 8;
    localparam int MW = 24;
    localparam int RW = 24;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            cke = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*EW-1:0] exp_a = '0;
    logic [N*EW-1:0] exp_b = '0;
    logic [N*MW-1:0] man_a = '0;
    logic [N*MW-1:0] man_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [EW+1:0]   rsp_exp;
    logic [RW-1:0]   rsp_man;
    logic            rsp_dbz;
    logic            rsp_tmo;
    logic            div_start;
    logic            div_done = 1'b0;
    logic [EW-1:0]   dexp_a;
    logic [EW-1:0]   dexp_b;
    logic [MW-1:0]   dman_a;
    logic [MW-1:0]   dman_b;
    logic [EW+1:0]   div_exp = '0;
    logic [RW-1:0]   div_man = '0;
    logic            busy;
    logic [1:0]      grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_ptfloat_div_ctrl #(
        .N_REQ   (N),
        .TIMEOUT (64),
        .ID_W    (2)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cke_i       (cke),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_exp_a_i (exp_a),
        .req_exp_b_i (exp_b),
        .req_man_a_i (man_a),
        .req_man_b_i (man_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_exp_o   (rsp_exp),
        .rsp_man_o   (rsp_man),
        .rsp_dbz_o   (rsp_dbz),
        .rsp_tmo_o   (rsp_tmo),
        .div_start_o (div_start),
        .div_done_i  (div_done),
        .div_exp_a_o (dexp_a),
        .div_exp_b_o (dexp_b),
        .div_man_a_o (dman_a),
        .div_man_b_o (dman_b),
        .div_exp_i   (div_exp),
        .div_man_i   (div_man),
        .busy_o      (busy),
        .grant_id_o  (grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n    = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        div_done  = 1'b0;
        cke       = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        tick();
    endtask

    task automatic set_ops(input int i, input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                           input logic [MW-1:0] ma, input logic [MW-1:0] mb);
        exp_a[i*EW +: EW] = ea;
        exp_b[i*EW +: EW] = eb;
        man_a[i*MW +: MW] = ma;
        man_b[i*MW +: MW] = mb;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rsp_valid !== '0 || req_ready !== '0 || div_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rv=%b rr=%b st=%b busy=%b exp all 0", rsp_valid, req_ready, div_start, busy);
        end
        checks++;
        if (rsp_dbz !== 1'b0 || rsp_tmo !== 1'b0 || rsp_exp !== '0 || rsp_man !== '0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_rsp got dbz=%b tmo=%b exp=%h man=%h id=%0d exp all 0", rsp_dbz, rsp_tmo, rsp_exp, rsp_man, grant_id);
        end
        checks++;
        if (dexp_a !== '0 || dexp_b !== '0 || dman_a !== '0 || dman_b !== '0) begin
            errors++;
            $display("FAIL reset_ops got %h %h %h %h exp 0", dexp_a, dexp_b, dman_a, dman_b);
        end
    endtask

    task automatic test_single();
        int starts;
        bit early;
        do_reset();
        set_ops(2, 8'd2, 8'd1, 24'hC00000, 24'h800000);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready got %b exp 0100", req_ready);
        end
        tick();
        req_valid = '0;
        starts = div_start ? 1 : 0;
        checks++;
        if (div_start !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_start got st=%b busy=%b id=%0d exp 1 1 2", div_start, busy, grant_id);
        end
        checks++;
        if (dexp_a !== 8'd2 || dexp_b !== 8'd1 || dman_a !== 24'hC00000 || dman_b !== 24'h800000) begin
            errors++;
            $display("FAIL single_ops got %h %h %h %h exp 02 01 c00000 800000", dexp_a, dexp_b, dman_a, dman_b);
        end
        early = 1'b0;
        for (int c = 2; c <= 36; c++) begin
            tick();
            if (div_start) starts++;
            if (rsp_valid !== '0) early = 1'b1;
            if (c == 36) begin
                div_done = 1'b1;
                div_exp  = 10'd1;
                div_man  = 24'hC00000;
            end
        end
        tick();
        div_done = 1'b0;
        div_exp  = '0;
        div_man  = '0;
        checks++;
        if (rsp_valid !== 4'b0100 || early) begin
            errors++;
            $display("FAIL single_rsp_valid got %b early=%b exp 0100 at cycle 37", rsp_valid, early);
        end
        checks++;
        if (rsp_exp !== 10'd1 || rsp_man !== 24'hC00000 || rsp_dbz !== 1'b0 || rsp_tmo !== 1'b0 || starts != 1) begin
            errors++;
            $display("FAIL single_rsp_data got exp=%h man=%h dbz=%b tmo=%b starts=%0d exp 001 c00000 0 0 1",
                     rsp_exp, rsp_man, rsp_dbz, rsp_tmo, starts);
        end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_idle got busy=%b rv=%b exp 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int w;
        logic [N-1:0] oh;
        do_reset();
        for (int i = 0; i < N; i++)
            set_ops(i, 8'(i + 1), 8'd1, 24'(24'h100000 * (i + 1)), 24'h800000);
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            w  = n % N;
            oh = N'(1) << w;
            #1;
            checks++;
            if (req_ready !== oh) begin
                errors++;
                $display("FAIL rr_ready[%0d] got %b exp %b", n, req_ready, oh);
            end
            tick();
            checks++;
            if (grant_id !== 2'(w) || div_start !== 1'b1 || dman_a !== 24'(24'h100000 * (w + 1))) begin
                errors++;
                $display("FAIL rr_start[%0d] got id=%0d st=%b mana=%h exp id=%0d", n, grant_id, div_start, dman_a, w);
            end
            tick();
            div_done = 1'b1;
            div_exp  = 10'(n + 3);
            div_man  = 24'(24'h000010 + n);
            tick();
            div_done = 1'b0;
            checks++;
            if (rsp_valid !== oh || rsp_man !== 24'(24'h000010 + n) || rsp_exp !== 10'(n + 3) || req_ready !== '0) begin
                errors++;
                $display("FAIL rr_rsp[%0d] got rv=%b man=%h exp=%h rr=%b exp rv=%b", n, rsp_valid, rsp_man, rsp_exp, req_ready, oh);
            end
            tick();
            checks++;
            if (rsp_valid !== oh || req_ready !== '0) begin
                errors++;
                $display("FAIL rr_hold[%0d] got rv=%b rr=%b exp rv=%b rr=0", n, rsp_valid, req_ready, oh);
            end
            rsp_ready = oh;
            tick();
            rsp_ready = '0;
        end
        req_valid = '0;
    endtask

    task automatic test_zero_div();
        bit started;
        do_reset();
        set_ops(1, 8'd5, 8'd3, 24'hA00000, 24'h000000);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        started = div_start;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_dbz !== 1'b1 || rsp_man !== '0 || rsp_exp !== '0 || rsp_tmo !== 1'b0) begin
            errors++;
            $display("FAIL zdiv_rsp got rv=%b dbz=%b man=%h exp=%h tmo=%b exp 0010 1 0 0 0",
                     rsp_valid, rsp_dbz, rsp_man, rsp_exp, rsp_tmo);
        end
        repeat (3) begin
            tick();
            if (div_start) started = 1'b1;
        end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = '0;
        if (div_start) started = 1'b1;
        checks++;
        if (started || busy !== 1'b0) begin
            errors++;
            $display("FAIL zdiv_nostart got started=%b busy=%b exp 0 0", started, busy);
        end
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        set_ops(0, 8'd4, 8'd2, 24'h900000, 24'h800000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        early = 1'b0;
        for (int c = 2; c <= 65; c++) begin
            tick();
            if (rsp_valid !== '0) early = 1'b1;
        end
        tick();
        checks++;
        if (early || rsp_valid !== 4'b0001 || rsp_tmo !== 1'b1 || rsp_exp !== '0 || rsp_man !== '0 || rsp_dbz !== 1'b0) begin
            errors++;
            $display("FAIL tmo_rsp got early=%b rv=%b tmo=%b exp=%h man=%h dbz=%b exp rv=0001 tmo=1 at cycle 66",
                     early, rsp_valid, rsp_tmo, rsp_exp, rsp_man, rsp_dbz);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        set_ops(1, 8'd7, 8'd2, 24'hB00000, 24'h800000);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        div_done = 1'b1;
        div_exp  = 10'd5;
        div_man  = 24'hB00000;
        tick();
        div_done = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_tmo !== 1'b0 || rsp_exp !== 10'd5 || rsp_man !== 24'hB00000) begin
            errors++;
            $display("FAIL tmo_next got rv=%b tmo=%b exp=%h man=%h exp 0010 0 005 b00000", rsp_valid, rsp_tmo, rsp_exp, rsp_man);
        end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_back_to_back();
        bit unstable;
        do_reset();
        set_ops(3, 8'd9, 8'd1, 24'hE00000, 24'h800000);
        set_ops(0, 8'd1, 8'd1, 24'h800000, 24'h000000);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1111;
        for (int c = 2; c <= 5; c++) tick();
        div_done = 1'b1;
        div_exp  = 10'd8;
        div_man  = 24'hE00000;
        tick();
        div_done = 1'b0;
        div_man  = 24'h123456;
        unstable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 4'b1000 || rsp_exp !== 10'd8 || rsp_man !== 24'hE00000 || req_ready !== '0)
                unstable = 1'b1;
            tick();
        end
        checks++;
        if (unstable || rsp_valid !== 4'b1000) begin
            errors++;
            $display("FAIL bp_stable got unstable=%b rv=%b exp 0 1000", unstable, rsp_valid);
        end
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = '0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_idle got busy=%b rv=%b rr=%b exp 0 0000 0001", busy, rsp_valid, req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_dbz !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL b2b_rsp got rv=%b dbz=%b id=%0d exp 0001 1 0", rsp_valid, rsp_dbz, grant_id);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid_busy();
        bit bad;
        do_reset();
        set_ops(2, 8'd3, 8'd2, 24'hF00000, 24'h900000);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (8) tick();
        #1 arst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || div_start !== 1'b0 || rsp_valid !== '0 || grant_id !== 2'd0 || dman_a !== '0 || dexp_a !== '0) begin
            errors++;
            $display("FAIL rst_busy got busy=%b st=%b rv=%b id=%0d mana=%h expa=%h exp all 0",
                     busy, div_start, rsp_valid, grant_id, dman_a, dexp_a);
        end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        div_done = 1'b1;
        div_man  = 24'h777777;
        tick();
        div_done = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            if (rsp_valid !== '0 || div_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_late_done got rv=%b st=%b busy=%b exp quiet", rsp_valid, div_start, busy);
        end
    endtask

    task automatic test_cke();
        do_reset();
        set_ops(0, 8'd2, 8'd2, 24'h800000, 24'h800000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        cke = 1'b0;
        repeat (3) tick();
        checks++;
        if (div_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cke_freeze got st=%b busy=%b exp 1 1", div_start, busy);
        end
        cke = 1'b1;
        tick();
        checks++;
        if (div_start !== 1'b0) begin
            errors++;
            $display("FAIL cke_resume got st=%b exp 0", div_start);
        end
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_div();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        test_cke();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
